// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
//   Shared defaults and types for the port-0 round-robin controller of the
//   32x256 byte-masked OpenRAM macro.
//   Contents:
//     DATA_WIDTH_DEF / ADDR_WIDTH_DEF / NUM_WMASKS_DEF  macro geometry defaults
//     state_t                                         controller FSM states
package sram_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int NUM_WMASKS_DEF = 4;

  // ST_INIT: zero-filling the array, clients blocked.
  // ST_RUN : clients arbitrated onto port 0.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: grants the first asserted request at or
//   after ptr, wrapping from NUM_REQ-1 back to 0. The pointer itself is owned
//   and advanced by the instantiating module.
//   Ports:
//     req        in   NUM_REQ   request vector
//     ptr        in   PTR_W     highest-priority requester index (< NUM_REQ)
//     grant      out  NUM_REQ   one-hot grant (all zero when no request)
//     grant_id   out  PTR_W     index of the granted requester
//     grant_any  out  1         a grant was issued
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_id,
  output logic               grant_any
);

  // One extra bit so ptr + i cannot overflow before the wrap is applied.
  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= NUM_REQ_W) begin
        sum = sum - NUM_REQ_W;
      end
      idx = sum[PTR_W-1:0];
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port0_rr_ctrl.sv
// sram_port0_rr_ctrl
//   Shares the 1RW port 0 of one byte-masked OpenRAM macro between NUM_REQ
//   requesters with round-robin arbitration. After reset (or a clear pulse in
//   RUN) the whole array is written with zeros, one word per cycle, before any
//   client is served. Read data returns to the issuing requester two cycles
//   after the handshake cycle.
//
//   Handshake: a requester transfers on a rising clk edge where its req_valid
//   and req_ready bits are both 1. req_ready is a combinational one-hot grant
//   that depends on req_valid in the same cycle; the requester holds its
//   fields stable while valid && !ready. Responses (rsp_valid) are a 1-cycle
//   strobe with no backpressure.
//
//   Ports:
//     clk, rst                   clock (also the macro clk0), sync active-high reset
//     clear                      re-run zero-fill (only acted on in RUN)
//     init_done                  1 while in RUN (mirrors the FSM state)
//     req_valid/ready/we         per-requester request handshake and direction
//     req_wmask/addr/wdata       packed per-requester fields, requester i at slice i
//     rsp_valid, rsp_rdata       one-hot read-return strobe and shared data
//     sram_csb0..sram_din0       macro port-0 controls (active-low csb/web)
//     sram_dout0                 macro port-0 read data
module sram_port0_rr_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_WMASKS = NUM_WMASKS_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  output logic                             init_done,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*NUM_WMASKS-1:0]    req_wmask,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             sram_csb0,
  output logic                             sram_web0,
  output logic [NUM_WMASKS-1:0]            sram_wmask0,
  output logic [ADDR_WIDTH-1:0]            sram_addr0,
  output logic [DATA_WIDTH-1:0]            sram_din0,
  input  logic [DATA_WIDTH-1:0]            sram_dout0
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(NUM_REQ - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_addr_q;
  logic [PTR_W-1:0]        ptr_q;

  // Read-tag pipeline: s1 = macro captured the read, s2 = data register
  // loaded and response presented.
  logic                    s1_valid_q, s2_valid_q;
  logic [PTR_W-1:0]        s1_id_q, s2_id_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [NUM_REQ-1:0]      grant;
  logic [PTR_W-1:0]        gnt_id;
  logic                    gnt_any;
  logic                    run_active;
  logic                    hs;

  logic                    sel_we;
  logic [NUM_WMASKS-1:0]   sel_wmask;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_id  (gnt_id),
    .grant_any (gnt_any)
  );

  assign sel_we    = req_we[gnt_id];
  assign sel_wmask = req_wmask[int'(gnt_id)*NUM_WMASKS +: NUM_WMASKS];
  assign sel_addr  = req_addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req_wdata[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];

  // rst is folded in combinationally so nothing is granted or written in a
  // cycle whose closing edge is a reset edge.
  assign run_active = (state_q == ST_RUN) && !rst;
  assign hs         = run_active && gnt_any;
  assign init_done  = (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    case (state_q)
      ST_INIT: begin
        if (!rst) begin
          sram_csb0   = 1'b0;
          sram_web0   = 1'b0;
          sram_wmask0 = '1;
          sram_addr0  = init_addr_q;
        end
        if (init_addr_q == '1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (hs) begin
          req_ready   = grant;
          sram_csb0   = 1'b0;
          sram_web0   = ~sel_we;
          sram_wmask0 = sel_wmask;
          sram_addr0  = sel_addr;
          sram_din0   = sel_wdata;
        end
        // A request granted in the same cycle still completes; clear only
        // takes effect from the next cycle.
        if (clear) begin
          state_d = ST_INIT;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_id_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;

      // Wraps to 0 after the last word, so the counter is already 0 whenever
      // INIT is re-entered; the explicit clear keeps that obvious.
      if (state_q == ST_INIT) begin
        init_addr_q <= init_addr_q + 1'b1;
      end else if (clear) begin
        init_addr_q <= '0;
      end

      if (hs) begin
        ptr_q <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
      end

      // Reads already in flight keep draining across a clear.
      s1_valid_q <= hs && !sel_we;
      s1_id_q    <= gnt_id;
      s2_valid_q <= s1_valid_q;
      s2_id_q    <= s1_id_q;
      if (s1_valid_q) begin
        rdata_q <= sram_dout0;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (s2_valid_q) begin
      rsp_valid[s2_id_q] = 1'b1;
    end
  end

  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_port0_rr_ctrl.sv
// tb_sram_port0_rr_ctrl
//   Directed bench for sram_port0_rr_ctrl with a behavioural model of the
//   OpenRAM macro port 0 (inputs captured at posedge, read data driven at the
//   following negedge). The model array starts full of non-zero garbage so the
//   zero-fill is observable.
module tb_sram_port0_rr_ctrl;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int MW = 4;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              init_done;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_we;
  logic [NR*MW-1:0]  req_wmask;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              sram_csb0;
  logic              sram_web0;
  logic [MW-1:0]     sram_wmask0;
  logic [AW-1:0]     sram_addr0;
  logic [DW-1:0]     sram_din0;
  logic [DW-1:0]     sram_dout0;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  sram_port0_rr_ctrl #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_WMASKS (MW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .init_done   (init_done),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_wmask   (req_wmask),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  // ---------------- macro model ----------------
  logic [DW-1:0] mem [DEPTH];
  logic          mem_loaded = 1'b0;
  logic [DW-1:0] rd_q = '0;
  logic          rd_pend = 1'b0;
  logic [DW-1:0] dout_q = '0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hBAD0_0000 | i;
      mem_loaded <= 1'b1;
    end else if (!sram_csb0 && !sram_web0) begin
      for (int k = 0; k < MW; k++)
        if (sram_wmask0[k]) mem[sram_addr0][8*k +: 8] <= sram_din0[8*k +: 8];
    end
    rd_pend <= !sram_csb0 && sram_web0;
    if (!sram_csb0 && sram_web0) rd_q <= mem[sram_addr0];
  end

  always @(negedge clk) begin
    if (rd_pend) dout_q <= rd_q;
  end

  assign sram_dout0 = dout_q;

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Present a request from the next negedge and hold it until granted; returns
  // #1 after the handshake edge with the request withdrawn.
  task automatic do_req(input int r, input logic we, input logic [3:0] m,
                        input logic [7:0] a, input logic [31:0] d, input string tag);
    int n;
    @(negedge clk);
    req_we[r]             = we;
    req_wmask[r*MW +: MW] = m;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*DW +: DW] = d;
    req_valid[r]          = 1'b1;
    n = 0;
    #1;
    while (!req_ready[r] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, " grant"}, 32'(req_ready[r]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic do_read(input int r, input logic [7:0] a, input logic [31:0] exp, input string tag);
    do_req(r, 1'b0, 4'h0, a, 32'h0, tag);
    check({tag, " no early rsp"}, 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1 << r);
    check({tag, " rsp_rdata"}, rsp_rdata, exp);
  endtask

  // Count rising edges until init_done goes high (bounded) and note any
  // response strobe seen while waiting.
  task automatic wait_init(output int n, output logic saw_rsp);
    n = 0;
    saw_rsp = 1'b0;
    while (!init_done && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (rsp_valid != '0) saw_rsp = 1'b1;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [NR-1:0] rr_gnt [4];
  logic [31:0]   rr_dat [4];
  int            n_init;
  logic          saw;

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    req_valid = '1;
    req_we    = '0;
    req_wmask = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset state (requests asserted on purpose: no grant may appear).
    repeat (3) @(posedge clk);
    #1;
    check("reset init_done", 32'(init_done), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset csb0", 32'(sram_csb0), 32'd1);

    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    wait_init(n_init, saw);
    check("init cycles", n_init, DEPTH);

    // Zero-filled corners; req0 then req1 leaves the pointer at 0.
    do_read(0, 8'hFF, 32'h0000_0000, "rd 0xFF");
    do_read(1, 8'h00, 32'h0000_0000, "rd 0x00");

    // Full-word write then read back.
    do_req(0, 1'b1, 4'hF, 8'h10, 32'hDEAD_BEEF, "wr 0x10");
    do_read(0, 8'h10, 32'hDEAD_BEEF, "rd 0x10");

    // Byte-mask merge: lanes 0 and 2 replaced.
    do_req(0, 1'b1, 4'hF, 8'h20, 32'h1122_3344, "wr 0x20 full");
    do_req(1, 1'b1, 4'h5, 8'h20, 32'hAABB_CCDD, "wr 0x20 m5");
    do_read(1, 8'h20, 32'h11BB_33DD, "rd 0x20");

    // Distinct data so response order is visible; last grant req1 -> ptr 0.
    do_req(0, 1'b1, 4'hF, 8'h01, 32'hA1A1_A1A1, "wr 0x01");
    do_req(1, 1'b1, 4'hF, 8'h02, 32'hB2B2_B2B2, "wr 0x02");

    // Both requesters hold reads for four cycles.
    rr_gnt[0] = 2'b01; rr_dat[0] = 32'hA1A1_A1A1;
    rr_gnt[1] = 2'b10; rr_dat[1] = 32'hB2B2_B2B2;
    rr_gnt[2] = 2'b01; rr_dat[2] = 32'hA1A1_A1A1;
    rr_gnt[3] = 2'b10; rr_dat[3] = 32'hB2B2_B2B2;
    @(negedge clk);
    req_we    = '0;
    req_addr  = {8'h02, 8'h01};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr grant %0d", k), 32'(req_ready), 32'(rr_gnt[k]));
      @(posedge clk);
      #1;
      if (k >= 1) begin
        check($sformatf("rr rsp_valid %0d", k - 1), 32'(rsp_valid), 32'(rr_gnt[k-1]));
        check($sformatf("rr rsp_rdata %0d", k - 1), rsp_rdata, rr_dat[k-1]);
      end
      if (k < 3) @(negedge clk);
    end
    req_valid = '0;
    @(posedge clk);
    #1;
    check("rr rsp_valid 3", 32'(rsp_valid), 32'(rr_gnt[3]));
    check("rr rsp_rdata 3", rsp_rdata, rr_dat[3]);
    @(posedge clk);
    #1;
    check("rr drained", 32'(rsp_valid), 32'd0);

    // Clear together with a read handshake: read still returns, then zero-fill.
    @(negedge clk);
    req_we[0]        = 1'b0;
    req_addr[7:0]    = 8'h10;
    req_valid[0]     = 1'b1;
    clear            = 1'b1;
    #1;
    check("clr grant", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    clear     = 1'b0;
    req_valid = '0;
    check("clr init_done low", 32'(init_done), 32'd0);
    @(posedge clk);
    #1;
    check("clr rsp_valid", 32'(rsp_valid), 32'd1);
    check("clr rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    wait_init(n_init, saw);
    check("clr init cycles", n_init + 1, DEPTH);
    check("clr no extra rsp", 32'(saw), 32'd0);
    do_read(0, 8'h10, 32'h0000_0000, "rd 0x10 after clr");
    do_read(1, 8'h20, 32'h0000_0000, "rd 0x20 after clr");

    // Reset right after a read handshake drops the response.
    do_req(0, 1'b0, 4'h0, 8'h01, 32'h0, "rd before rst");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst drop rsp", 32'(rsp_valid), 32'd0);
    check("rst init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_init(n_init, saw);
    check("rst no rsp", 32'(saw), 32'd0);
    check("rst init cycles", n_init, DEPTH);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
